// File: rtl/adder_pkg.sv
// ============================================================================
// Module : adder_pkg
// Shared width and result type for the pipelined adder and its result FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int ADDER_N = 32;

    typedef struct packed {
        logic               cout;
        logic [ADDER_N-1:0] s;
    } add_result_t;

endpackage

`default_nettype wire

// File: rtl/fifo_regfile.sv
// ============================================================================
// Module : fifo_regfile
// DEPTH x WIDTH register array, one synchronous write port, one async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_regfile #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // Storage is deliberately not reset; occupancy lives in the pointers.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/adder_result_fifo.sv
// ============================================================================
// Module : adder_result_fifo
// Show-ahead FIFO for {cout, s} adder results with drop counting on overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int N     = ADDER_N,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           in_s,
    input  logic                   in_cout,
    input  logic                   in_valid,
    output logic [N:0]             out_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    input  logic                   clr_ovf
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_we;
    add_result_t        w_wr_word;
    logic [N:0]         w_rd_word;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;
    assign w_we    = w_push && rstn;

    assign w_wr_word.cout = in_cout;
    assign w_wr_word.s    = in_s;

    fifo_regfile #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_word),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            // A drop in the same cycle as a clear restarts the tally at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clr_ovf) begin
                    r_drop_cnt <= 16'd1;
                end else if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign out_sum   = w_empty ? '0 : w_rd_word;
    assign out_valid = !w_empty;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
// ============================================================================
// Module : tb_adder_result_fifo
// Directed vector table plus hand-written sequences for adder_result_fifo.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_adder_result_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  in_s;
    logic          in_cout;
    logic          in_valid;
    logic [N:0]    out_sum;
    logic          out_valid;
    logic          out_ready;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          clr_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_s      (in_s),
        .in_cout   (in_cout),
        .in_valid  (in_valid),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    typedef struct {
        logic        v;
        logic [32:0] d;
        logic        rdy;
        logic        clr;
        logic [3:0]  e_cnt;
        logic [32:0] e_sum;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [32:0] d, input logic rdy, input logic clr);
        in_valid  = v;
        in_cout   = d[32];
        in_s      = d[31:0];
        out_ready = rdy;
        clr_ovf   = clr;
    endtask

    function automatic void add(input logic v, input logic [32:0] d, input logic rdy,
                                input logic clr, input int cnt, input logic [32:0] sum,
                                input logic ovf, input int drp);
        vec_t t;
        t.v = v; t.d = d; t.rdy = rdy; t.clr = clr;
        t.e_cnt = 4'(cnt); t.e_sum = sum;
        t.e_full = (cnt == DEPTH); t.e_empty = (cnt == 0);
        t.e_ovf = ovf; t.e_drop = 16'(drp);
        tbl.push_back(t);
    endfunction

    // Model-driven step: checks head before the edge, updates model, checks after.
    task automatic mstep(input string nm, input logic v, input logic [32:0] d,
                         input logic rdy, inout int drops);
        logic pop;
        logic [32:0] front;
        drive(v, d, rdy, 1'b0);
        chk({nm, "_valid"}, out_valid, q.size() != 0);
        if (q.size() != 0) begin
            front = q[0];
            chk({nm, "_head"}, out_sum, front);
        end
        pop = (q.size() != 0) && rdy;
        if (v && (q.size() < DEPTH || pop)) q.push_back(d);
        else if (v) drops++;
        if (pop) void'(q.pop_front());
        tick();
        chk({nm, "_count"}, count, q.size());
    endtask

    initial begin
        int drops;
        logic [31:0] a, b;
        logic [15:0] drop_before;

        // Basic three-entry hold and drain.
        add(1, 33'd333,     0, 0, 1, 33'd333, 0, 0);
        add(1, 33'd1318735, 0, 0, 2, 33'd333, 0, 0);
        add(1, 33'd2637137, 0, 0, 3, 33'd333, 0, 0);
        add(0, 33'd0,       0, 0, 3, 33'd333, 0, 0);
        add(0, 33'd0,       1, 0, 2, 33'd1318735, 0, 0);
        add(0, 33'd0,       1, 0, 1, 33'd2637137, 0, 0);
        add(0, 33'd0,       1, 0, 0, 33'd0, 0, 0);
        // Ten pushes into eight slots: two drops.
        for (int i = 0; i < 10; i++)
            add(1, 33'(100 + i), 0, 0, (i < 8) ? i + 1 : 8, 33'd100,
                (i >= 8), (i >= 8) ? i - 7 : 0);
        for (int k = 0; k < 8; k++)
            add(0, 33'd0, 1, 0, 7 - k, (k < 7) ? 33'(101 + k) : 33'd0, 1, 2);
        add(0, 33'd0, 0, 1, 0, 33'd0, 0, 0);

        drive(0, 33'd0, 0, 0);
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            tick();
            chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_sum", i), out_sum, tbl[i].e_sum);
            chk($sformatf("vec%0d_valid", i), out_valid, !tbl[i].e_empty);
            chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].e_ovf);
            chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].e_drop);
        end

        // Full FIFO streaming: simultaneous push and pop for 20 cycles.
        drops = 0;
        q.delete();
        for (int i = 0; i < 8; i++) mstep("fill", 1, 33'(200 + i), 0, drops);
        for (int i = 0; i < 20; i++) begin
            mstep("stream", 1, 33'(300 + i), 1, drops);
            chk("stream_full", full, 1);
            chk("stream_drop", drop_cnt, 0);
        end
        for (int i = 0; i < 8; i++) mstep("sdrain", 0, 33'd0, 1, drops);
        chk("stream_ovf", overflow, 0);

        // Clear coinciding with a drop.
        for (int i = 0; i < 8; i++) mstep("cfill", 1, 33'(400 + i), 0, drops);
        mstep("cdrop", 1, 33'd500, 0, drops);
        mstep("cdrop", 1, 33'd501, 0, drops);
        chk("pre_clr_drop", drop_cnt, 2);
        drive(1, 33'd502, 0, 1);
        tick();
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_cnt, 1);
        drive(0, 33'd0, 0, 1);
        tick();
        chk("clr_only_ovf", overflow, 0);
        chk("clr_only_cnt", drop_cnt, 0);
        for (int i = 0; i < 8; i++) mstep("cdrain", 0, 33'd0, 1, drops);

        // Wrap and carry: 200 results with random consumer readiness.
        drops = 0;
        a = 32'hF000_0000;
        b = 32'h2000_0000;
        for (int i = 0; i < 200; i++) begin
            mstep("wrap", 1, {1'b0, a} + {1'b0, b}, 1'($urandom_range(0, 1)), drops);
            a += 32'd1318402;
            b += 32'd182553;
        end
        chk("wrap_drop", drop_cnt, drops);
        chk("wrap_ovf", overflow, drops != 0);
        drop_before = drop_cnt;
        for (int i = 0; i < 40; i++) begin
            mstep("full_rate", 1, {1'b0, a} + {1'b0, b}, 1, drops);
            a += 32'd1318402;
            b += 32'd182553;
        end
        chk("full_rate_drop", drop_cnt, drop_before);

        // Reset in the middle of operation with entries held.
        drive(0, 33'd0, 0, 1);
        tick();
        for (int i = 0; i < DEPTH; i++) mstep("rdrain", 0, 33'd0, 1, drops);
        for (int i = 0; i < 5; i++) mstep("rfill", 1, 33'(600 + i), 0, drops);
        chk("pre_rst_count", count, 5);
        drive(1, 33'd700, 0, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drive(0, 33'd0, 0, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_sum", out_sum, 0);
        drive(1, 33'h1_0000_0777, 0, 0);
        tick();
        drive(0, 33'd0, 0, 0);
        chk("post_rst_count", count, 1);
        chk("post_rst_sum", out_sum, 33'h1_0000_0777);
        drive(0, 33'd0, 1, 0);
        tick();
        chk("post_rst_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
